// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: reset-and-run sequencer for one or more RISC-V pipeline cores.
// Holds per-core resets for RST_HOLD_CYCLES, counts run cycles, accepts per-core
// soft-reset requests while running, and ends a run when every core has halted
// or the run-cycle budget expires.
//
// Optional feature macro: RUN_CTRL_HALT_DETECT_EN
//   defined   -> halt_i is tracked in the sticky halted mask and a full mask ends the run
//   undefined -> halt_i is ignored, halted stays 0, runs end only on timeout
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          start-run pulse (honoured in IDLE and DONE)
//   soft_rst_req   per-core soft-reset request (honoured in RUN)
//   halt_i         per-core halt indication
//   core_reset_n_o per-core active-low reset to the cores
//   busy           high in RESET or RUN
//   done           high in DONE
//   timeout        run ended on the cycle budget
//   halted         sticky per-core halt mask
//   cycle_cnt      run cycles elapsed
module riscv_run_ctrl #(
    parameter int unsigned NUM_CORES       = 1,
    parameter int unsigned RST_HOLD_CYCLES = 2,
    parameter int unsigned MAX_RUN_CYCLES  = 25,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] soft_rst_req,
    input  logic [NUM_CORES-1:0] halt_i,
    output logic [NUM_CORES-1:0] core_reset_n_o,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] halted,
    output logic [CNT_W-1:0]     cycle_cnt
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [HOLD_W-1:0] SOFT_LOAD = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] RST_LOAD  = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(MAX_RUN_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                         state_q, state_d;
    logic [HOLD_W-1:0]                  rst_cnt_q, rst_cnt_d;
    logic [NUM_CORES-1:0][HOLD_W-1:0]   soft_cnt_q, soft_cnt_d;
    logic [NUM_CORES-1:0]               core_rst_n_d;
    logic [NUM_CORES-1:0]               run_rst_n_c;
    logic [NUM_CORES-1:0]               halted_d;
    logic [CNT_W-1:0]                   cycle_cnt_d;
    logic                               timeout_d;
    logic                               busy_d;
    logic                               done_d;
    logic                               all_halted_c;

    // Halt-mask termination is only meaningful when halt detection is built in.
`ifdef RUN_CTRL_HALT_DETECT_EN
    assign all_halted_c = &halted;
`else
    logic unused_halt_c;
    assign all_halted_c  = 1'b0;
    assign unused_halt_c = ^halt_i;
`endif

    // State and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            rst_cnt_q      <= '0;
            soft_cnt_q     <= '0;
            core_reset_n_o <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            halted         <= '0;
            cycle_cnt      <= '0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            soft_cnt_q     <= soft_cnt_d;
            core_reset_n_o <= core_rst_n_d;
            busy           <= busy_d;
            done           <= done_d;
            timeout        <= timeout_d;
            halted         <= halted_d;
            cycle_cnt      <= cycle_cnt_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        soft_cnt_d   = soft_cnt_q;
        core_rst_n_d = core_reset_n_o;
        run_rst_n_c  = '0;
        halted_d     = halted;
        cycle_cnt_d  = cycle_cnt;
        timeout_d    = timeout;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RESET;
                    rst_cnt_d    = RST_LOAD;
                    soft_cnt_d   = '0;
                    core_rst_n_d = '0;
                    halted_d     = '0;
                    cycle_cnt_d  = '0;
                    timeout_d    = 1'b0;
                end
            end

            S_RESET: begin
                core_rst_n_d = '0;
                if (rst_cnt_q == '0) begin
                    state_d      = S_RUN;
                    core_rst_n_d = '1;
                end else begin
                    rst_cnt_d = rst_cnt_q - HOLD_W'(1);
                end
            end

            S_RUN: begin
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    // A request (re)loads the hold; otherwise the hold drains.
                    if (soft_rst_req[i]) begin
                        soft_cnt_d[i] = SOFT_LOAD;
                    end else if (soft_cnt_q[i] != '0) begin
                        soft_cnt_d[i] = soft_cnt_q[i] - HOLD_W'(1);
                    end
                    // Soft-reset clear has priority over a same-cycle halt.
                    if (soft_rst_req[i]) begin
                        halted_d[i] = 1'b0;
                    end
`ifdef RUN_CTRL_HALT_DETECT_EN
                    else if (halt_i[i] && (soft_cnt_q[i] == '0)) begin
                        halted_d[i] = 1'b1;
                    end
`endif
                    run_rst_n_c[i] = (soft_cnt_d[i] == '0);
                end

                // Core resets and the cycle count freeze on the way into DONE.
                if (all_halted_c) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (cycle_cnt == RUN_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    cycle_cnt_d  = cycle_cnt + CNT_W'(1);
                    core_rst_n_d = run_rst_n_c;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RESET) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl with 2 cores, 2 hold cycles, 25-cycle budget.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_riscv_run_ctrl;

    localparam int unsigned NC = 2;
    localparam int unsigned CW = 16;

`ifdef RUN_CTRL_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [NC-1:0] soft_rst_req;
    logic [NC-1:0] halt_i;
    logic [NC-1:0] core_reset_n_o;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [NC-1:0] halted;
    logic [CW-1:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_run_ctrl #(
        .NUM_CORES      (NC),
        .RST_HOLD_CYCLES(2),
        .MAX_RUN_CYCLES (25),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .soft_rst_req  (soft_rst_req),
        .halt_i        (halt_i),
        .core_reset_n_o(core_reset_n_o),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .halted        (halted),
        .cycle_cnt     (cycle_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start; returns in the first RESET cycle.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; soft_rst_req = '0; halt_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({core_reset_n_o, busy, done, timeout, halted, cycle_cnt} !== {2'b00, 3'b000, 2'b00, 16'd0}) begin
            n_err++;
            $display("FAIL reset_in: got core=%b busy=%b done=%b to=%b halted=%b cnt=%0d expected all zero",
                     core_reset_n_o, busy, done, timeout, halted, cycle_cnt);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            soft_rst_req = (i == 1) ? 2'b11 : 2'b00;
            tick();
            n_cmp++;
            if ({core_reset_n_o, busy, done, cycle_cnt} !== {2'b00, 2'b00, 16'd0}) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got core=%b busy=%b done=%b cnt=%0d expected core=00 busy=0 done=0 cnt=0",
                         i, core_reset_n_o, busy, done, cycle_cnt);
            end
        end
        soft_rst_req = '0;
    endtask

    task automatic test_timeout_run();
        start_run();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({core_reset_n_o, busy, done} !== {2'b00, 2'b10}) begin
                n_err++;
                $display("FAIL to_reset_hold[%0d]: got core=%b busy=%b done=%b expected core=00 busy=1 done=0",
                         i, core_reset_n_o, busy, done);
            end
            tick();
        end
        for (int k = 0; k < 25; k++) begin
            n_cmp++;
            if ({core_reset_n_o, busy, done, cycle_cnt} !== {2'b11, 2'b10, 16'(k)}) begin
                n_err++;
                $display("FAIL to_run[%0d]: got core=%b busy=%b done=%b cnt=%0d expected core=11 busy=1 done=0 cnt=%0d",
                         k, core_reset_n_o, busy, done, cycle_cnt, k);
            end
            start = (k == 3);   // start while busy must be ignored
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if ({done, timeout, busy, core_reset_n_o, cycle_cnt} !== {3'b110, 2'b11, 16'd24}) begin
            n_err++;
            $display("FAIL to_done: got done=%b to=%b busy=%b core=%b cnt=%0d expected done=1 to=1 busy=0 core=11 cnt=24",
                     done, timeout, busy, core_reset_n_o, cycle_cnt);
        end
    endtask

    task automatic test_halt_run();
        start_run();
        tick(); tick();
        for (int k = 0; k < 9; k++) begin
            if (k == 6) begin
                n_cmp++;
                if (halted !== (HALT_EN ? 2'b01 : 2'b00)) begin
                    n_err++;
                    $display("FAIL halt_first: got halted=%b expected %b", halted, HALT_EN ? 2'b01 : 2'b00);
                end
            end
            halt_i = (k == 5) ? 2'b01 : ((k == 8) ? 2'b10 : 2'b00);
            tick();
        end
        halt_i = '0;
        n_cmp++;
        if ({halted, busy, cycle_cnt} !== {(HALT_EN ? 2'b11 : 2'b00), 1'b1, 16'd9}) begin
            n_err++;
            $display("FAIL halt_mask: got halted=%b busy=%b cnt=%0d expected halted=%b busy=1 cnt=9",
                     halted, busy, cycle_cnt, HALT_EN ? 2'b11 : 2'b00);
        end
        tick();
        n_cmp++;
        if (done !== HALT_EN) begin
            n_err++;
            $display("FAIL halt_done_latency: got done=%b expected %b", done, HALT_EN);
        end
        for (int g = 0; g < 40 && !done; g++) tick();
        n_cmp++;
        if ({done, timeout, cycle_cnt} !== {1'b1, !HALT_EN, (HALT_EN ? 16'd9 : 16'd24)}) begin
            n_err++;
            $display("FAIL halt_end: got done=%b to=%b cnt=%0d expected done=1 to=%b cnt=%0d",
                     done, timeout, cycle_cnt, !HALT_EN, HALT_EN ? 9 : 24);
        end
    endtask

    task automatic test_soft_reset();
        start_run();
        tick(); tick();
        for (int k = 0; k <= 13; k++) begin
            if (k == 10) begin
                n_cmp++;
                if (halted !== (HALT_EN ? 2'b10 : 2'b00)) begin
                    n_err++;
                    $display("FAIL soft_pre_halted: got halted=%b expected %b", halted, HALT_EN ? 2'b10 : 2'b00);
                end
            end
            if (k >= 11) begin
                n_cmp++;
                if ({core_reset_n_o, halted, cycle_cnt} !== {((k < 13) ? 2'b01 : 2'b11), 2'b00, 16'(k)}) begin
                    n_err++;
                    $display("FAIL soft_hold[%0d]: got core=%b halted=%b cnt=%0d expected core=%b halted=00 cnt=%0d",
                             k, core_reset_n_o, halted, cycle_cnt, (k < 13) ? 2'b01 : 2'b11, k);
                end
            end
            halt_i       = (k == 3 || k == 11) ? 2'b10 : 2'b00;   // second halt lands inside the hold
            soft_rst_req = (k == 10) ? 2'b10 : 2'b00;
            if (k < 13) tick();
        end
        halt_i = '0; soft_rst_req = '0;
        for (int g = 0; g < 40 && !done; g++) tick();
        n_cmp++;
        if ({done, timeout, cycle_cnt} !== {2'b11, 16'd24}) begin
            n_err++;
            $display("FAIL soft_end: got done=%b to=%b cnt=%0d expected done=1 to=1 cnt=24", done, timeout, cycle_cnt);
        end
    endtask

    task automatic test_simul_term();
        start_run();
        tick(); tick();
        for (int k = 0; k < 25; k++) begin
            if (k == 24) begin
                n_cmp++;
                if ({halted, cycle_cnt} !== {(HALT_EN ? 2'b11 : 2'b00), 16'd24}) begin
                    n_err++;
                    $display("FAIL simul_mask: got halted=%b cnt=%0d expected halted=%b cnt=24",
                             halted, cycle_cnt, HALT_EN ? 2'b11 : 2'b00);
                end
            end
            halt_i = (k == 3) ? 2'b01 : ((k == 23) ? 2'b10 : 2'b00);
            tick();
        end
        halt_i = '0;
        n_cmp++;
        if ({done, timeout, cycle_cnt} !== {1'b1, !HALT_EN, 16'd24}) begin
            n_err++;
            $display("FAIL simul_end: got done=%b to=%b cnt=%0d expected done=1 to=%b cnt=24",
                     done, timeout, cycle_cnt, !HALT_EN);
        end
    endtask

    task automatic test_async_reset();
        start_run();
        tick(); tick();
        repeat (12) tick();
        n_cmp++;
        if ({busy, cycle_cnt} !== {1'b1, 16'd12}) begin
            n_err++;
            $display("FAIL async_pre: got busy=%b cnt=%0d expected busy=1 cnt=12", busy, cycle_cnt);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({core_reset_n_o, busy, done, timeout, halted, cycle_cnt} !== {2'b00, 3'b000, 2'b00, 16'd0}) begin
            n_err++;
            $display("FAIL async_now: got core=%b busy=%b done=%b to=%b halted=%b cnt=%0d expected all zero",
                     core_reset_n_o, busy, done, timeout, halted, cycle_cnt);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        start_run();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({core_reset_n_o, busy} !== 3'b001) begin
                n_err++;
                $display("FAIL rerun_hold[%0d]: got core=%b busy=%b expected core=00 busy=1", i, core_reset_n_o, busy);
            end
            tick();
        end
        n_cmp++;
        if ({core_reset_n_o, cycle_cnt} !== {2'b11, 16'd0}) begin
            n_err++;
            $display("FAIL rerun_run0: got core=%b cnt=%0d expected core=11 cnt=0", core_reset_n_o, cycle_cnt);
        end
        for (int g = 0; g < 40 && !done; g++) tick();
        n_cmp++;
        if ({done, timeout, cycle_cnt} !== {2'b11, 16'd24}) begin
            n_err++;
            $display("FAIL rerun_end: got done=%b to=%b cnt=%0d expected done=1 to=1 cnt=24", done, timeout, cycle_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timeout_run();
        test_halt_run();
        test_soft_reset();
        test_simul_term();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
